// File: rtl/egr_mri_pkg.sv
// Shared defaults, types and helpers for the egress Mesh Read Interface
// request-side receiver.
package egr_mri_pkg;

    localparam int N_REQ_DEF        = 4;
    localparam int ADDR_W_DEF       = 20;
    localparam int DATA_W_DEF       = 64;
    localparam int TAG_W_DEF        = 4;
    localparam int MESH_CREDITS_DEF = 8;

    localparam int N_TAGS_DEF   = 2 ** TAG_W_DEF;
    localparam int REQ_ID_W_DEF = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

    typedef logic [TAG_W_DEF-1:0]    mri_tag_t;
    typedef logic [REQ_ID_W_DEF-1:0] mri_req_id_t;
    typedef logic [ADDR_W_DEF-1:0]   mri_addr_t;

    // Index of the lowest set bit of free_map; zero when nothing is free.
    function automatic mri_tag_t lowest_free(input logic [N_TAGS_DEF-1:0] free_map);
        mri_tag_t idx;
        idx = '0;
        for (int i = N_TAGS_DEF - 1; i >= 0; i--) begin
            idx = free_map[i] ? mri_tag_t'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/egr_rr_arb.sv
// N-way round-robin arbiter: one-hot grant plus winner index, search starts at
// the internal pointer which moves past the winner when upd is asserted.
module egr_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic             upd,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] win
);

    localparam logic [IDX_W:0]   N_L   = (IDX_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    logic [IDX_W-1:0] ptr_r;
    logic [N-1:0]     req_rot_s;
    logic [IDX_W-1:0] off_s;
    logic [IDX_W:0]   sum_s;
    logic             hit_s;
    logic             take_s;

    // Rotate requests so bit 0 is the pointer position, then pick the first hit.
    always_comb begin
        req_rot_s = N'({req, req} >> ptr_r);
        off_s     = '0;
        hit_s     = 1'b0;
        take_s    = 1'b0;
        for (int k = 0; k < N; k++) begin
            take_s = en && req_rot_s[k] && !hit_s;
            off_s  = take_s ? IDX_W'(k) : off_s;
            hit_s  = hit_s | take_s;
        end
        sum_s = {1'b0, ptr_r} + {1'b0, off_s};
        win   = (sum_s >= N_L) ? IDX_W'(sum_s - N_L) : sum_s[IDX_W-1:0];
        gnt   = hit_s ? (N'(1) << win) : '0;
    end

    // Pointer moves to the port after the winner on a taken grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (upd) begin
            ptr_r <= (win == LAST) ? '0 : win + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/egr_mri_rrq.sv
// Egress MRI read-request receiver: round-robin over requesters, tag allocation,
// credit-controlled issue to the mesh and tag-routed response return.
module egr_mri_rrq
    import egr_mri_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int TAG_W        = TAG_W_DEF,
    parameter int MESH_CREDITS = MESH_CREDITS_DEF
) (
    input  logic                    cclk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    mesh_rd_valid,
    output logic [ADDR_W-1:0]       mesh_rd_addr,
    output logic [TAG_W-1:0]        mesh_rd_tag,
    input  logic                    mesh_credit_ret,
    input  logic                    mesh_rsp_valid,
    input  logic [TAG_W-1:0]        mesh_rsp_tag,
    input  logic [DATA_W-1:0]       mesh_rsp_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    idle,
    output logic                    err_credit_ovf,
    output logic                    err_spurious_rsp
);

    localparam int N_TAGS = 2 ** TAG_W;
    localparam int CRD_W  = $clog2(MESH_CREDITS + 1);
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MESH_CREDITS);

    logic [N_REQ-1:0]  grant_s;
    logic [ID_W-1:0]   win_s;
    logic              eligible_s;
    logic              accept_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [TAG_W-1:0]  alloc_tag_s;

    logic [N_TAGS-1:0] busy_r;
    logic [N_TAGS-1:0] busy_nxt_s;
    logic [N_TAGS-1:0] clr_s;
    logic [N_TAGS-1:0] set_s;
    logic [ID_W-1:0]   owner_r [N_TAGS];

    logic [CRD_W-1:0]  credits_r;
    logic [CRD_W-1:0]  credits_nxt_s;
    logic              crd_ovf_s;
    logic              rsp_hit_s;
    logic              rsp_spur_s;

    logic              mesh_rd_valid_r;
    logic [ADDR_W-1:0] mesh_rd_addr_r;
    logic [TAG_W-1:0]  mesh_rd_tag_r;
    logic [N_REQ-1:0]  rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              idle_r;
    logic              err_credit_ovf_r;
    logic              err_spurious_rsp_r;

    egr_rr_arb #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk   (cclk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (eligible_s),
        .upd   (accept_s),
        .gnt   (grant_s),
        .win   (win_s)
    );

    // Grant eligibility, tag pick and response classification.
    always_comb begin
        eligible_s  = (credits_r != '0) && !(&busy_r);
        accept_s    = |grant_s;
        win_addr_s  = req_addr[int'(win_s) * ADDR_W +: ADDR_W];
        alloc_tag_s = TAG_W'(lowest_free(N_TAGS_DEF'(~busy_r)));
        rsp_hit_s   = mesh_rsp_valid && busy_r[mesh_rsp_tag];
        rsp_spur_s  = mesh_rsp_valid && !busy_r[mesh_rsp_tag];
        // The allocated tag comes from the registered bitmap, so it can never
        // collide with the tag freed by a response in the same cycle.
        clr_s       = {{(N_TAGS - 1){1'b0}}, rsp_hit_s} << mesh_rsp_tag;
        set_s       = {{(N_TAGS - 1){1'b0}}, accept_s} << alloc_tag_s;
        busy_nxt_s  = (busy_r & ~clr_s) | set_s;
    end

    // Credit counter next state; a return at full count saturates and flags.
    always_comb begin
        credits_nxt_s = credits_r;
        crd_ovf_s     = 1'b0;
        case ({accept_s, mesh_credit_ret})
            2'b10: begin
                credits_nxt_s = credits_r - CRD_W'(1);
            end
            2'b01: begin
                if (credits_r == CRD_MAX) begin
                    crd_ovf_s = 1'b1;
                end else begin
                    credits_nxt_s = credits_r + CRD_W'(1);
                end
            end
            default: begin
                credits_nxt_s = credits_r;
            end
        endcase
    end

    // Tag owner table: records which requester each issued tag belongs to.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < N_TAGS; t++) begin
                owner_r[t] <= '0;
            end
        end else if (accept_s) begin
            owner_r[alloc_tag_s] <= win_s;
        end
    end

    // Main state and registered outputs.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r             <= '0;
            credits_r          <= CRD_MAX;
            mesh_rd_valid_r    <= 1'b0;
            mesh_rd_addr_r     <= '0;
            mesh_rd_tag_r      <= '0;
            rsp_valid_r        <= '0;
            rsp_data_r         <= '0;
            idle_r             <= 1'b1;
            err_credit_ovf_r   <= 1'b0;
            err_spurious_rsp_r <= 1'b0;
        end else begin
            busy_r             <= busy_nxt_s;
            credits_r          <= credits_nxt_s;
            mesh_rd_valid_r    <= accept_s;
            mesh_rd_addr_r     <= accept_s ? win_addr_s : mesh_rd_addr_r;
            mesh_rd_tag_r      <= accept_s ? alloc_tag_s : mesh_rd_tag_r;
            rsp_valid_r        <= rsp_hit_s ? ({{(N_REQ - 1){1'b0}}, 1'b1} << owner_r[mesh_rsp_tag])
                                            : '0;
            rsp_data_r         <= rsp_hit_s ? mesh_rsp_data : rsp_data_r;
            idle_r             <= (busy_nxt_s == '0) && (credits_nxt_s == CRD_MAX);
            err_credit_ovf_r   <= err_credit_ovf_r | crd_ovf_s;
            err_spurious_rsp_r <= err_spurious_rsp_r | rsp_spur_s;
        end
    end

    assign req_ready        = grant_s;
    assign mesh_rd_valid    = mesh_rd_valid_r;
    assign mesh_rd_addr     = mesh_rd_addr_r;
    assign mesh_rd_tag      = mesh_rd_tag_r;
    assign rsp_valid        = rsp_valid_r;
    assign rsp_data         = rsp_data_r;
    assign idle             = idle_r;
    assign err_credit_ovf   = err_credit_ovf_r;
    assign err_spurious_rsp = err_spurious_rsp_r;

endmodule

// File: tb/tb_egr_mri_rrq.sv
// Scoreboard bench for egr_mri_rrq: expected issues/responses are queued when
// stimulus is applied and checked when the DUT strobes them.
module tb_egr_mri_rrq;

    logic         cclk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = 4'd0;
    logic [79:0]  req_addr = 80'd0;
    logic [3:0]   req_ready;
    logic         mesh_rd_valid;
    logic [19:0]  mesh_rd_addr;
    logic [3:0]   mesh_rd_tag;
    logic         mesh_credit_ret = 1'b0;
    logic         mesh_rsp_valid = 1'b0;
    logic [3:0]   mesh_rsp_tag = 4'd0;
    logic [63:0]  mesh_rsp_data = 64'd0;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic         idle;
    logic         err_credit_ovf;
    logic         err_spurious_rsp;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] iss_q[$];   // {addr, tag}
    logic [67:0] rsp_q[$];   // {port one-hot, data}
    logic [23:0] iss_e;
    logic [67:0] rsp_e;

    egr_mri_rrq dut (
        .cclk             (cclk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .mesh_rd_valid    (mesh_rd_valid),
        .mesh_rd_addr     (mesh_rd_addr),
        .mesh_rd_tag      (mesh_rd_tag),
        .mesh_credit_ret  (mesh_credit_ret),
        .mesh_rsp_valid   (mesh_rsp_valid),
        .mesh_rsp_tag     (mesh_rsp_tag),
        .mesh_rsp_data    (mesh_rsp_data),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .idle             (idle),
        .err_credit_ovf   (err_credit_ovf),
        .err_spurious_rsp (err_spurious_rsp)
    );

    always #5 cclk = ~cclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Anything queued one cycle earlier must appear now; nothing else may.
    always @(negedge cclk) begin
        if (iss_q.size() != 0) begin
            iss_e = iss_q.pop_front();
            chk("rd_valid", 64'(mesh_rd_valid), 64'd1);
            chk("rd_addr", 64'(mesh_rd_addr), 64'(iss_e[23:4]));
            chk("rd_tag", 64'(mesh_rd_tag), 64'(iss_e[3:0]));
        end else if (mesh_rd_valid) begin
            chk("rd_unexpected", 64'(mesh_rd_valid), 64'd0);
        end
        if (rsp_q.size() != 0) begin
            rsp_e = rsp_q.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(rsp_e[67:64]));
            chk("rsp_data", rsp_data, rsp_e[63:0]);
        end else if (rsp_valid != 4'd0) begin
            chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end
    end

    // One cycle of stimulus; port p presents address base ^ (p << 12).
    task automatic step(input logic [3:0] v, input logic [19:0] base, input logic ret,
                        input logic rv, input logic [3:0] rtag, input logic [63:0] rdata,
                        input logic [3:0] exp_rdy, input logic [3:0] exp_tag,
                        input logic [3:0] exp_rsp);
        int pidx;
        @(negedge cclk);
        req_valid = v;
        for (int p = 0; p < 4; p++) begin
            req_addr[p*20 +: 20] = base ^ (20'(p) << 12);
        end
        mesh_credit_ret = ret;
        mesh_rsp_valid  = rv;
        mesh_rsp_tag    = rtag;
        mesh_rsp_data   = rdata;
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        pidx = 0;
        for (int p = 0; p < 4; p++) begin
            if (exp_rdy[p]) pidx = p;
        end
        if (exp_rdy != 4'd0) iss_q.push_back({base ^ (20'(pidx) << 12), exp_tag});
        if (exp_rsp != 4'd0) rsp_q.push_back({exp_rsp, rdata});
    endtask

    task automatic quiet();
        step(4'd0, 20'd0, 1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge cclk);
        rst_n = 1'b0;
        req_valid = 4'd0;
        mesh_credit_ret = 1'b0;
        mesh_rsp_valid = 1'b0;
        #1;
        chk("rst_rd_valid", 64'(mesh_rd_valid), 64'd0);
        chk("rst_rd_addr", 64'(mesh_rd_addr), 64'd0);
        chk("rst_rd_tag", 64'(mesh_rd_tag), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_err_ovf", 64'(err_credit_ovf), 64'd0);
        chk("rst_err_spur", 64'(err_spurious_rsp), 64'd0);
        repeat (2) @(negedge cclk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Single request on port 2 at 0x00ABC, response routed back.
        do_reset();
        step(4'b0100, 20'h02ABC, 1'b0, 1'b0, 4'd0, 64'd0, 4'b0100, 4'd0, 4'd0);
        step(4'd0, 20'd0, 1'b0, 1'b1, 4'd0, 64'hDEAD, 4'd0, 4'd0, 4'b0100);
        chk("idle_after_issue", 64'(idle), 64'd0);
        step(4'd0, 20'd0, 1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        chk("idle_credit_out", 64'(idle), 64'd0);
        quiet();
        chk("idle_restored", 64'(idle), 64'd1);

        // Fairness with a credit back every cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 20'h30000 + 20'(i * 257), 1'b1, 1'b0, 4'd0, 64'd0,
                 4'b0001 << (i % 4), 4'(i), 4'd0);
        end
        quiet();
        chk("fair_no_ovf", 64'(err_credit_ovf), 64'd0);

        // Credit exhaustion, then a single returned credit.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 20'h51000 + 20'(i * 3), 1'b0, 1'b0, 4'd0, 64'd0,
                 4'b0001 << (i % 4), 4'(i), 4'd0);
        end
        step(4'b1111, 20'h52000, 1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        step(4'b1111, 20'h52000, 1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        step(4'b1111, 20'h52000, 1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        step(4'b1111, 20'h53456, 1'b0, 1'b0, 4'd0, 64'd0, 4'b0001, 4'd8, 4'd0);
        step(4'b1111, 20'h54000, 1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        quiet();

        // Tag exhaustion (credits recycled), freeing tag 5 re-grants tag 5.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(4'b1111, 20'h60000 + 20'(i * 17), 1'b1, 1'b0, 4'd0, 64'd0,
                 4'b0001 << (i % 4), 4'(i), 4'd0);
        end
        step(4'b1111, 20'h61000, 1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        step(4'b1111, 20'h61000, 1'b0, 1'b1, 4'd5, 64'h5555_0000_0000_0005,
             4'd0, 4'd0, 4'b0010);
        step(4'b1111, 20'h62345, 1'b0, 1'b0, 4'd0, 64'd0, 4'b0001, 4'd5, 4'd0);
        step(4'b1111, 20'h63000, 1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        quiet();

        // Spurious response and credit overflow; still exactly 8 credits after.
        do_reset();
        step(4'd0, 20'd0, 1'b0, 1'b1, 4'd9, 64'hBAD, 4'd0, 4'd0, 4'd0);
        quiet();
        chk("spur_set", 64'(err_spurious_rsp), 64'd1);
        chk("ovf_clear", 64'(err_credit_ovf), 64'd0);
        step(4'd0, 20'd0, 1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        quiet();
        chk("ovf_set", 64'(err_credit_ovf), 64'd1);
        chk("ovf_idle", 64'(idle), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step(4'b0001, 20'h70000 + 20'(i), 1'b0, 1'b0, 4'd0, 64'd0, 4'b0001, 4'(i), 4'd0);
        end
        step(4'b0001, 20'h71000, 1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0);
        quiet();
        chk("spur_sticky", 64'(err_spurious_rsp), 64'd1);

        // Reset with three tags outstanding; a late response is spurious.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 20'h80000 + 20'(i * 5), 1'b0, 1'b0, 4'd0, 64'd0,
                 4'b0001 << i, 4'(i), 4'd0);
        end
        quiet();
        do_reset();
        step(4'd0, 20'd0, 1'b0, 1'b1, 4'd1, 64'h1234, 4'd0, 4'd0, 4'd0);
        quiet();
        chk("late_rsp_spur", 64'(err_spurious_rsp), 64'd1);
        chk("late_rsp_idle", 64'(idle), 64'd1);

        @(negedge cclk);
        #1;
        chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
